// File: rtl/mips_fetch_stage.sv
// rtl/mips_fetch_stage.sv - pipe_MIPS32 instruction-fetch stage with program memory, branch redirect, stall and halt throttling
module mips_fetch_stage #(
    parameter int          DEPTH  = 1024,
    parameter logic [5:0]  HLT_OP = 6'h3f
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_i,
    input  logic        br_taken_i,
    input  logic [31:0] br_target_i,
    input  logic        halt_i,
    input  logic        pm_we,
    input  logic [31:0] pm_addr,
    input  logic [31:0] pm_wdata,
    output logic [31:0] if_id_ir,
    output logic [31:0] if_id_npc,
    output logic        if_id_valid,
    output logic [31:0] pc_o,
    output logic        fetch_halted
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_HOLD_HLT = 2'd1,
        S_HALTED   = 2'd2
    } state_t;

    logic [31:0] ProgMem [0:DEPTH-1];

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pc;
    logic [31:0] pc_nxt;
    logic [31:0] ir_nxt;
    logic [31:0] npc_nxt;
    logic        valid_nxt;
    logic        pc_in_range;
    logic        wr_in_range;
    logic [31:0] fetch_word;
    logic        fetch_is_hlt;

    // Out-of-range PC reads as HLT so a runaway program stops cleanly
    always_comb begin
        pc_in_range  = (pc < 32'(DEPTH));
        wr_in_range  = (pm_addr < 32'(DEPTH));
        fetch_word   = pc_in_range ? ProgMem[pc[AW-1:0]] : {HLT_OP, 26'h0};
        fetch_is_hlt = (fetch_word[31:26] == HLT_OP);
    end

    // Loader write port; not reset so a loaded program survives a pipeline reset
    always_ff @(posedge clk) begin
        if (pm_we && wr_in_range) begin
            ProgMem[pm_addr[AW-1:0]] <= pm_wdata;
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: halt beats redirect beats stall beats normal fetch
    always_comb begin
        state_nxt = state;
        if (halt_i || state == S_HALTED) begin
            state_nxt = S_HALTED;
        end else if (br_taken_i) begin
            state_nxt = S_RUN;
        end else if (stall_i) begin
            state_nxt = state;
        end else if (state == S_RUN && fetch_is_hlt) begin
            state_nxt = S_HOLD_HLT;
        end
    end

    // Next PC and IF/ID contents for each state and request combination
    always_comb begin
        pc_nxt    = pc;
        ir_nxt    = if_id_ir;
        npc_nxt   = if_id_npc;
        valid_nxt = if_id_valid;
        if (halt_i || state == S_HALTED) begin
            ir_nxt    = 32'h0;
            valid_nxt = 1'b0;
        end else if (br_taken_i) begin
            pc_nxt    = br_target_i;
            ir_nxt    = 32'h0;
            valid_nxt = 1'b0;
        end else if (stall_i) begin
            pc_nxt    = pc;
        end else if (state == S_RUN) begin
            ir_nxt    = fetch_word;
            npc_nxt   = pc + 32'd1;
            valid_nxt = 1'b1;
            // HLT is issued once and the PC parks on it
            pc_nxt    = fetch_is_hlt ? pc : pc + 32'd1;
        end else begin
            ir_nxt    = 32'h0;
            valid_nxt = 1'b0;
        end
    end

    // PC and IF/ID pipeline register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc          <= 32'h0;
            if_id_ir    <= 32'h0;
            if_id_npc   <= 32'h0;
            if_id_valid <= 1'b0;
        end else begin
            pc          <= pc_nxt;
            if_id_ir    <= ir_nxt;
            if_id_npc   <= npc_nxt;
            if_id_valid <= valid_nxt;
        end
    end

    assign pc_o         = pc;
    assign fetch_halted = (state == S_HALTED);

endmodule

// File: tb/tb_mips_fetch_stage.sv
// tb/tb_mips_fetch_stage.sv - self-checking bench for mips_fetch_stage
module tb_mips_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall_i;
    logic        br_taken_i;
    logic [31:0] br_target_i;
    logic        halt_i;
    logic        pm_we;
    logic [31:0] pm_addr;
    logic [31:0] pm_wdata;
    logic [31:0] if_id_ir;
    logic [31:0] if_id_npc;
    logic        if_id_valid;
    logic [31:0] pc_o;
    logic        fetch_halted;

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    mips_fetch_stage #(.DEPTH(1024), .HLT_OP(6'h3f)) dut (
        .clk          (clk),
        .reset        (reset),
        .stall_i      (stall_i),
        .br_taken_i   (br_taken_i),
        .br_target_i  (br_target_i),
        .halt_i       (halt_i),
        .pm_we        (pm_we),
        .pm_addr      (pm_addr),
        .pm_wdata     (pm_wdata),
        .if_id_ir     (if_id_ir),
        .if_id_npc    (if_id_npc),
        .if_id_valid  (if_id_valid),
        .pc_o         (pc_o),
        .fetch_halted (fetch_halted)
    );

    // Reference model: memory image plus the architectural view of the stage
    logic [31:0] mmem [0:1023];
    logic [31:0] m_pc;
    logic [31:0] m_ir;
    logic [31:0] m_npc;
    logic        m_valid;
    logic        m_halted;
    logic        m_hlt_issued;

    function automatic logic [31:0] mword(input logic [31:0] a);
        logic [9:0] idx;
        idx = a[9:0];
        return (a < 32'd1024) ? mmem[idx] : 32'hfc000000;
    endfunction

    task automatic model_reset();
        m_pc         = 32'h0;
        m_ir         = 32'h0;
        m_npc        = 32'h0;
        m_valid      = 1'b0;
        m_halted     = 1'b0;
        m_hlt_issued = 1'b0;
    endtask

    task automatic model_step();
        logic [31:0] w;
        w = mword(m_pc);
        if (m_halted || halt_i) begin
            m_halted = 1'b1;
            m_ir     = 32'h0;
            m_valid  = 1'b0;
        end else if (br_taken_i) begin
            m_pc         = br_target_i;
            m_ir         = 32'h0;
            m_valid      = 1'b0;
            m_hlt_issued = 1'b0;
        end else if (!stall_i) begin
            if (m_hlt_issued) begin
                m_ir    = 32'h0;
                m_valid = 1'b0;
            end else begin
                m_ir    = w;
                m_npc   = m_pc + 32'd1;
                m_valid = 1'b1;
                if (w[31:26] == 6'h3f) m_hlt_issued = 1'b1;
                else                   m_pc = m_pc + 32'd1;
            end
        end
        if (pm_we && pm_addr < 32'd1024) mmem[pm_addr[9:0]] = pm_wdata;
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) model_reset();
            else        model_step();
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model
    initial begin
        forever begin
            @(negedge clk);
            if (chk_on) begin
                chk("model pc",     pc_o,                  m_pc);
                chk("model ir",     if_id_ir,              m_ir);
                chk("model npc",    if_id_npc,             m_npc);
                chk("model valid",  {31'h0, if_id_valid},  {31'h0, m_valid});
                chk("model halted", {31'h0, fetch_halted}, {31'h0, m_halted});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] d);
        pm_we    = 1'b1;
        pm_addr  = a;
        pm_wdata = d;
        mmem[a[9:0]] = d;
        tick();
        pm_we = 1'b0;
    endtask

    task automatic fetch_is(input string name, input logic [31:0] ir, input logic [31:0] npc);
        chk({name, " ir"},    if_id_ir, ir);
        chk({name, " npc"},   if_id_npc, npc);
        chk({name, " valid"}, {31'h0, if_id_valid}, 32'h1);
    endtask

    task automatic bubble_at(input string name, input logic [31:0] pc);
        chk({name, " ir"},    if_id_ir, 32'h0);
        chk({name, " valid"}, {31'h0, if_id_valid}, 32'h0);
        chk({name, " pc"},    pc_o, pc);
    endtask

    logic [31:0] prog [0:7];

    initial begin
        reset       = 1'b0;
        stall_i     = 1'b0;
        br_taken_i  = 1'b0;
        br_target_i = 32'h0;
        halt_i      = 1'b0;
        pm_we       = 1'b0;
        pm_addr     = 32'h0;
        pm_wdata    = 32'h0;
        prog[0] = 32'h280a00c8; prog[1] = 32'h21430000;
        prog[2] = 32'h28020001; prog[3] = 32'h14431000;
        prog[4] = 32'h2c630001; prog[5] = 32'h0e94a000;
        prog[6] = 32'h3460fffc; prog[7] = 32'hfc000000;
        for (int i = 0; i < 1024; i++) mmem[i] = 32'h0;
        model_reset();
        for (int i = 0; i < 16; i++) load(32'(i), (i < 8) ? prog[i] : 32'h0c631800);

        chk_on = 1'b1;
        chk("reset pc",     pc_o, 32'h0);
        chk("reset ir",     if_id_ir, 32'h0);
        chk("reset valid",  {31'h0, if_id_valid}, 32'h0);
        chk("reset halted", {31'h0, fetch_halted}, 32'h0);

        // Straight-line fetch
        reset = 1'b1;
        tick(); fetch_is("seq0", 32'h280a00c8, 32'd1);
        tick(); fetch_is("seq1", 32'h21430000, 32'd2);
        tick(); fetch_is("seq2", 32'h28020001, 32'd3);
        tick(); tick();
        chk("seq pc", pc_o, 32'd5);

        // Asynchronous reset between edges
        #3 reset = 1'b0;
        #1;
        chk("async pc",    pc_o, 32'h0);
        chk("async ir",    if_id_ir, 32'h0);
        chk("async valid", {31'h0, if_id_valid}, 32'h0);
        #2 reset = 1'b1;
        tick(); fetch_is("post reset", 32'h280a00c8, 32'd1);
        tick(); chk("pre stall pc", pc_o, 32'd2);

        // Stall holds pc and IF/ID
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall pc", pc_o, 32'd2);
            chk("stall ir", if_id_ir, 32'h21430000);
        end
        stall_i = 1'b0;
        tick(); fetch_is("after stall", 32'h28020001, 32'd3);
        tick();

        // Same-edge write returns the old word; out-of-range write ignored
        pm_we = 1'b1; pm_addr = 32'd4; pm_wdata = 32'h2c630002;
        tick(); fetch_is("old word", 32'h2c630001, 32'd5);
        pm_addr = 32'd1027; pm_wdata = 32'hfc000000;
        tick(); fetch_is("pc5", 32'h0e94a000, 32'd6);
        pm_we = 1'b0;
        chk("pre branch pc", pc_o, 32'd6);

        // Branch redirect back to 3
        br_taken_i = 1'b1; br_target_i = 32'd3;
        tick(); br_taken_i = 1'b0;
        bubble_at("redirect", 32'd3);
        tick(); fetch_is("target", 32'h14431000, 32'd4);
        tick(); fetch_is("new word", 32'h2c630002, 32'd5);
        tick(); tick();

        // HLT issued once then bubbles
        tick(); fetch_is("hlt", 32'hfc000000, 32'd8);
        chk("hlt pc", pc_o, 32'd7);
        tick(); bubble_at("hold1", 32'd7);
        tick(); bubble_at("hold2", 32'd7);

        // Redirect wins over stall and leaves HOLD_HLT
        br_taken_i = 1'b1; stall_i = 1'b1; br_target_i = 32'd2;
        tick(); br_taken_i = 1'b0; stall_i = 1'b0;
        bubble_at("br+stall", 32'd2);
        tick(); fetch_is("br+stall fetch", 32'h28020001, 32'd3);

        // Out-of-range target fetches HLT
        br_taken_i = 1'b1; br_target_i = 32'd2000;
        tick(); br_taken_i = 1'b0;
        bubble_at("far redirect", 32'd2000);
        tick(); fetch_is("far hlt", 32'hfc000000, 32'd2001);
        tick(); bubble_at("far hold", 32'd2000);

        // Halt beats a simultaneous redirect and is sticky
        halt_i = 1'b1; br_taken_i = 1'b1; br_target_i = 32'd0;
        tick(); halt_i = 1'b0; br_taken_i = 1'b0;
        bubble_at("halt", 32'd2000);
        chk("halt flag", {31'h0, fetch_halted}, 32'h1);
        br_taken_i = 1'b1;
        tick(); br_taken_i = 1'b0;
        bubble_at("halted br", 32'd2000);
        stall_i = 1'b1;
        tick(); stall_i = 1'b0;
        tick();
        chk("halted sticky", {31'h0, fetch_halted}, 32'h1);

        // Reset clears HALTED
        #2 reset = 1'b0;
        #1;
        chk("unhalt flag", {31'h0, fetch_halted}, 32'h0);
        chk("unhalt pc", pc_o, 32'h0);
        chk_on = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
